// File: rtl/store_unit.sv
// store_unit: single-request word store with load/store handshake.
//
// A request (store or load) is accepted in IDLE, executed in WRITE or READ,
// and answered in RESP, where it is held until the consumer takes it. Each
// implemented word carries a written flag: loads of never-written words
// return 0. store_count tracks how many distinct words have been written.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          asynchronous active-high reset
//   req_valid    request present
//   req_ready    unit can accept a request (IDLE only)
//   req_we       1 = store, 0 = load
//   req_addr     word address
//   Ro           data to store
//   rsp_valid    response present (RESP only)
//   rsp_ready    consumer accepts response
//   stored_data  store: echo of written word; load: word read
//   rsp_err      request addressed a word at or beyond DEPTH
//   store_count  distinct words written since reset (saturates at DEPTH)
module store_unit #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] Ro,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] stored_data,
   output logic              rsp_err,
   output logic [ADDR_W:0]   store_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;
   logic [DEPTH-1:0]  written;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign in_range = ({1'b0, addr_q} < DEPTH_C);
   assign idx      = addr_q[IDX_W-1:0];

   // Next-state and handshake outputs. Store/load direction is carried by
   // the WRITE/READ state itself, so req_we need not be captured.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_we ? WRITE : READ;
            end
         end
         WRITE, READ: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // err_q keeps its value after the response; masking here keeps rsp_err
   // low everywhere except RESP.
   assign rsp_err = rsp_valid & err_q;

   // Request capture: frozen from acceptance until the next acceptance.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         addr_q <= req_addr;
         data_q <= Ro;
      end
   end

   // Storage array is not reset; validity is carried by the written flags.
   always_ff @(posedge clk) begin
      if (state == WRITE && in_range) begin
         mem[idx] <= data_q;
      end
   end

   // Control state, flags, counter and response register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         written     <= '0;
         store_count <= '0;
         stored_data <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == WRITE) begin
            stored_data <= in_range ? data_q : '0;
            err_q       <= ~in_range;
            // Only the first write to a word counts; this also bounds the
            // counter at DEPTH.
            if (in_range && !written[idx]) begin
               written[idx] <= 1'b1;
               store_count  <= store_count + 1'b1;
            end
         end else if (state == READ) begin
            stored_data <= (in_range && written[idx]) ? mem[idx] : '0;
            err_q       <= ~in_range;
         end
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized checks of store_unit against a
// behavioural word-memory model, on a full-depth (16) and a partial-depth
// (10) instance.
module tb_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [1:0]  rsp_ready;
   logic [3:0]  req_addr [2];
   logic [19:0] ro [2];

   logic        req_ready0, rsp_valid0, rsp_err0;
   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [19:0] sd0, sd1;
   logic [4:0]  cnt0, cnt1;

   store_unit #(.DATA_W(20), .ADDR_W(4), .DEPTH(16)) dut0 (
      .clk(clk), .rst(rst[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready0),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .Ro(ro[0]),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready[0]),
      .stored_data(sd0), .rsp_err(rsp_err0), .store_count(cnt0)
   );

   store_unit #(.DATA_W(20), .ADDR_W(4), .DEPTH(10)) dut1 (
      .clk(clk), .rst(rst[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready1),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .Ro(ro[1]),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready[1]),
      .stored_data(sd1), .rsp_err(rsp_err1), .store_count(cnt1)
   );

   // Reference model: per instance, word contents, written flags, count.
   int          depth [2] = '{16, 10};
   logic [19:0] m_mem [2][16];
   bit          m_wr  [2][16];
   int          m_cnt [2];

   int checks   = 0;
   int failures = 0;

   function automatic logic f_ready(input int s);
      return (s == 0) ? req_ready0 : req_ready1;
   endfunction
   function automatic logic f_valid(input int s);
      return (s == 0) ? rsp_valid0 : rsp_valid1;
   endfunction
   function automatic logic f_err(input int s);
      return (s == 0) ? rsp_err0 : rsp_err1;
   endfunction
   function automatic logic [19:0] f_sd(input int s);
      return (s == 0) ? sd0 : sd1;
   endfunction
   function automatic logic [4:0] f_cnt(input int s);
      return (s == 0) ? cnt0 : cnt1;
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic clear_model(input int s);
      for (int i = 0; i < 16; i++) m_wr[s][i] = 1'b0;
      m_cnt[s] = 0;
   endtask

   task automatic check_reset_outputs(input int s, input string tag);
      check({tag, "_req_ready"},   f_ready(s), 1);
      check({tag, "_rsp_valid"},   f_valid(s), 0);
      check({tag, "_rsp_err"},     f_err(s),   0);
      check({tag, "_stored_data"}, f_sd(s),    0);
      check({tag, "_store_count"}, f_cnt(s),   0);
   endtask

   task automatic do_reset(input int s);
      rst[s] = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs(s, "reset");
      clear_model(s);
      rst[s] = 1'b0;
   endtask

   // One complete request/response; stall = cycles rsp_ready is held low
   // in RESP while a competing request is kept on the inputs.
   task automatic txn(input int s, input bit we, input logic [3:0] a,
                      input logic [19:0] d, input int stall);
      logic [19:0] exp_d;
      bit          exp_e;
      bit          inr;
      inr   = (int'(a) < depth[s]);
      exp_e = !inr;
      if (!inr)    exp_d = '0;
      else if (we) exp_d = d;
      else         exp_d = m_wr[s][a] ? m_mem[s][a] : 20'h0;
      if (we && inr) begin
         if (!m_wr[s][a]) m_cnt[s]++;
         m_wr[s][a]  = 1'b1;
         m_mem[s][a] = d;
      end

      @(negedge clk);
      check("idle_ready", f_ready(s), 1);
      req_valid[s] = 1'b1;
      req_we[s]    = we;
      req_addr[s]  = a;
      ro[s]        = d;
      @(posedge clk);
      #1;
      // Leave a different request asserted; it must not be taken or leak in.
      req_we[s]   = 1'($urandom_range(0, 1));
      req_addr[s] = 4'($urandom_range(0, 15));
      ro[s]       = 20'($urandom);
      @(negedge clk);
      check("busy_rsp_valid", f_valid(s), 0);
      check("busy_req_ready", f_ready(s), 0);
      @(negedge clk);
      check("rsp_valid",   f_valid(s), 1);
      check("rsp_data",    f_sd(s),    exp_d);
      check("rsp_err",     f_err(s),   exp_e);
      check("store_count", f_cnt(s),   m_cnt[s]);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", f_valid(s), 1);
         check("stall_data",  f_sd(s),    exp_d);
         check("stall_err",   f_err(s),   exp_e);
         check("stall_ready", f_ready(s), 0);
      end
      rsp_ready[s] = 1'b1;
      req_valid[s] = 1'b0;
      @(posedge clk);
      #1;
      rsp_ready[s] = 1'b0;
      @(negedge clk);
      check("post_valid", f_valid(s), 0);
      check("post_err",   f_err(s),   0);
      check("post_data",  f_sd(s),    exp_d);
      check("post_ready", f_ready(s), 1);
   endtask

   initial begin
      rst       = 2'b00;
      req_valid = 2'b00;
      req_we    = 2'b00;
      rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = '0;
         ro[i]       = '0;
      end
      #1;
      do_reset(0);
      do_reset(1);

      // Store then load on the full-depth instance.
      txn(0, 1'b1, 4'd3, 20'h12345, 0);
      check("first_store_count", f_cnt(0), 1);
      txn(0, 1'b0, 4'd3, 20'h0, 0);
      txn(0, 1'b0, 4'd5, 20'h0, 0);

      // Rewrites of one word count once.
      txn(0, 1'b1, 4'd3, 20'hABCDE, 0);
      txn(0, 1'b1, 4'd3, 20'hABCDE, 0);
      check("rewrite_count", f_cnt(0), 1);
      txn(0, 1'b0, 4'd3, 20'h0, 0);

      // Held response with a competing request.
      txn(0, 1'b0, 4'd3, 20'h0, 5);

      // Range boundary on the partial-depth instance.
      txn(1, 1'b1, 4'd9,  20'h99999, 0);
      txn(1, 1'b1, 4'd10, 20'h0AAAA, 0);
      txn(1, 1'b1, 4'd12, 20'h54321, 1);
      check("oob_store_count", f_cnt(1), 1);
      txn(1, 1'b0, 4'd12, 20'h0, 0);
      txn(1, 1'b0, 4'd9,  20'h0, 0);

      // Randomized traffic on both instances.
      for (int n = 0; n < 60; n++) begin
         for (int s = 0; s < 2; s++) begin
            txn(s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                20'($urandom), int'($urandom_range(0, 2)));
         end
      end

      // Write every address: the counter stops at DEPTH.
      for (int a = 0; a < 16; a++) begin
         txn(1, 1'b1, 4'(a), 20'($urandom), 0);
      end
      check("count_saturates", f_cnt(1), 10);

      // Make sure address 7 holds data and the response is nonzero.
      txn(0, 1'b1, 4'd7, 20'h7A7A7, 0);

      // Reset while a store is in WRITE.
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 4'd7;
      ro[0]        = 20'h77777;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      rst[0]       = 1'b1;
      #1;
      check_reset_outputs(0, "abort");
      clear_model(0);
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      txn(0, 1'b0, 4'd7, 20'h0, 0);
      check("abort_count", f_cnt(0), 0);
      txn(0, 1'b1, 4'd2, 20'h0BEEF, 0);
      txn(0, 1'b0, 4'd2, 20'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
